// File: rtl/async_counter_pkg.sv
// Shared constants for the ripple counter and its toggle stages.
package async_counter_pkg;

  // Baseline counter width (number of ripple stages).
  localparam int DEFAULT_WIDTH = 4;

  // Per-stage propagation allowance. The RTL stages themselves are zero-delay
  // so they stay synthesizable. Consumers budget this much time per stage
  // before they sample the count.
  localparam int STAGE_DELAY = 1;

  // Worst-case time for a carry to ripple through every stage.
  function automatic int settle_time(input int width);
    return width * STAGE_DELAY;
  endfunction

endpackage : async_counter_pkg

// File: rtl/async_counter_tff.sv
// Toggle flip-flop with an active-low asynchronous clear and true/complement
// outputs. The complement output clocks the next ripple stage.
module async_counter_tff (
  input  logic clk,
  input  logic rst_n,
  output logic q,
  output logic q_n
);

  // Toggle on every rising clock edge; clear immediately while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the clear lives in the sensitivity list, so it acts without a
    // clock edge. State is updated with <= so that neighbouring stages read
    // each other's pre-edge values.
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= ~q;
    end
  end

  assign q_n = ~q;

endmodule : async_counter_tff

// File: rtl/async_counter.sv
// Asynchronous (ripple) binary up-counter. Stage 0 toggles on clk_i. Each
// higher stage toggles when the stage below it falls from 1 to 0. The stage
// below drives that edge as a rising edge on its q_n output. There is no
// next-state adder. The count is the concatenation of the stage outputs.
// q_o is only meaningful after the ripple has settled.
module async_counter
  import async_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] stage_clk;

  // The top stage's complement has no stage above it to clock.
  logic unused_q_n;
  assign unused_q_n = q_n[WIDTH-1];

  // Clock chain: clk_i feeds stage 0. Each later stage is clocked by the
  // complement of the stage below it. The reset goes straight to every stage
  // rather than rippling through the chain.
  assign stage_clk[0] = clk_i;

  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign stage_clk[k] = q_n[k-1];
    end

    async_counter_tff u_tff (
      .clk   (stage_clk[k]),
      .rst_n (rst_n_i),
      .q     (q[k]),
      .q_n   (q_n[k])
    );
  end

  assign q_o = q;

endmodule : async_counter

// File: tb/tb_async_counter.sv
// Directed bench for the 4-bit ripple counter. It samples the count a settle
// interval after each rising clock edge.
module tb_async_counter;
  import async_counter_pkg::*;

  localparam int W      = 4;
  localparam int SETTLE = settle_time(W) + 1;

  logic         clk_i;
  logic         rst_n_i;
  logic [W-1:0] q_o;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] expected;

  async_counter #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .q_o     (q_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard time limit so the run can never hang.
  initial begin
    #20000;
    $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Wait for the next rising edge, then let the ripple settle.
  task automatic tick();
    @(posedge clk_i);
    #(SETTLE);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b1;
    #10;                       // t=10
    rst_n_i = 1'b0;
    #2;                        // t=12
    total++;
    if (q_o !== 4'd0) $display("FAIL reset_assert: q_o=%0d required 0", q_o);
    else passed++;
    #5;                        // t=17, edge at t=15 must have been ignored
    total++;
    if (q_o !== 4'd0) $display("FAIL reset_ignores_edge: q_o=%0d required 0", q_o);
    else passed++;
    #3;                        // t=20
    rst_n_i = 1'b1;
    tick();                    // edge at t=25
    total++;
    if (q_o !== 4'd1) $display("FAIL first_edge: q_o=%0d required 1", q_o);
    else passed++;
    tick();                    // edge at t=35
    total++;
    if (q_o !== 4'd2) $display("FAIL second_edge: q_o=%0d required 2", q_o);
    else passed++;
  endtask

  task automatic test_wrap();
    rst_n_i = 1'b0;
    #2;
    rst_n_i = 1'b1;
    total++;
    if (q_o !== 4'd0) $display("FAIL wrap_start: q_o=%0d required 0", q_o);
    else passed++;
    expected = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      expected = expected + 4'd1;
      total++;
      if (q_o !== expected)
        $display("FAIL wrap_edge_%0d: q_o=%0d required %0d", i + 1, q_o, expected);
      else passed++;
    end
  endtask

  task automatic test_ripple_carry();
    // The count is 0 here. Advance to 7, then push the long carry 7 -> 8.
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (q_o !== 4'd7) $display("FAIL carry_pre: q_o=%0d required 7", q_o);
    else passed++;
    tick();
    total++;
    if (q_o !== 4'd8) $display("FAIL carry_7_to_8: q_o=%0d required 8", q_o);
    else passed++;
  endtask

  task automatic test_reset_pulse();
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (q_o !== 4'd11) $display("FAIL pulse_pre: q_o=%0d required 11", q_o);
    else passed++;
    rst_n_i = 1'b0;
    #1;
    total++;
    if (q_o !== 4'd0) $display("FAIL pulse_clear: q_o=%0d required 0", q_o);
    else passed++;
    #2;
    rst_n_i = 1'b1;
    #1;
    total++;
    if (q_o !== 4'd0) $display("FAIL pulse_release: q_o=%0d required 0", q_o);
    else passed++;
    tick();
    total++;
    if (q_o !== 4'd1) $display("FAIL pulse_next_edge: q_o=%0d required 1", q_o);
    else passed++;
  endtask

  task automatic test_reset_hold();
    tick();
    tick();                    // count is 3: reset must clear several bits at once
    rst_n_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (q_o !== 4'd0) $display("FAIL hold_edge_%0d: q_o=%0d required 0", i + 1, q_o);
      else passed++;
    end
    rst_n_i = 1'b1;
    tick();
    total++;
    if (q_o !== 4'd1) $display("FAIL hold_release: q_o=%0d required 1", q_o);
    else passed++;
    tick();
    total++;
    if (q_o !== 4'd2) $display("FAIL hold_second: q_o=%0d required 2", q_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_ripple_carry();
    test_reset_pulse();
    test_reset_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_async_counter
